// File: rtl/err_stats_pkg.sv
// err_stats_pkg
// Shared definitions for the err_stats_4x4 error-metric accumulator:
//   - state_t       : run-control FSM state encoding (IDLE, RUN, DONE)
//   - DEF_W         : default operand width
//   - DEF_N_SAMPLES : default number of samples per run
//   - cnt_width()   : bits needed to count 0..n inclusive
//   - sum_width()   : bits needed for the error-distance sum of n samples
package err_stats_pkg;

    localparam int DEF_W         = 4;
    localparam int DEF_N_SAMPLES = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A counter that must be able to hold the value n itself needs
    // clog2(n+1) bits, not clog2(n).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Each error distance fits in 2w bits; summing n of them adds at most
    // cnt_width(n) bits, so the sum can never wrap.
    function automatic int sum_width(input int w, input int n);
        return 2 * w + cnt_width(n);
    endfunction

endpackage

// File: rtl/err_stats_4x4_err_dist.sv
// err_dist
// Combinational error-distance kernel. It forms the exact product of the
// two operands and the absolute distance to the approximate product.
// Ports:
//   i_a, i_b : W-bit unsigned operands
//   i_y      : 2W-bit approximate product (unsigned)
//   o_exact  : 2W-bit exact product i_a*i_b
//   o_ed     : 2W-bit |o_exact - i_y|
//   o_err    : high when o_ed is nonzero
module err_dist
    import err_stats_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic [2*W-1:0] i_y,
    output logic [2*W-1:0] o_exact,
    output logic [2*W-1:0] o_ed,
    output logic           o_err
);

    logic [2*W-1:0] w_exact;

    // Widen both operands before multiplying so the full product is kept.
    assign w_exact = (2*W)'(i_a) * (2*W)'(i_b);
    assign o_exact = w_exact;
    assign o_ed    = (w_exact >= i_y) ? (w_exact - i_y) : (i_y - w_exact);
    assign o_err   = (o_ed != '0);

endmodule

// File: rtl/err_stats_4x4.sv
// err_stats_4x4
// Run-based error-metric accumulator for an approximate WxW multiplier.
// After 'start' it accepts N_SAMPLES (a, b, y) samples and accumulates the
// error count, the sum of error distances and the maximum error distance.
// The results are then frozen in DONE until the next 'start'.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : begin a new run (ignored while a run is in progress)
//   in_valid     : sample present on a/b/y
//   in_ready     : high while a run is in progress (depends on state only)
//   a, b, y      : operands and approximate product under test
//   busy, done   : run in progress / results valid and held
//   sample_count : samples accepted in the current or last run
//   err_count    : samples where y != a*b
//   ed_sum       : sum of |a*b - y|
//   ed_max       : max of |a*b - y|
// Optional feature, enabled by defining macro ERR_BIAS_EN:
//   bias_sum     : signed sum of (y - a*b)
//   ed_min_nz    : smallest nonzero error distance (all-ones if no error occurred)
module err_stats_4x4
    import err_stats_pkg::*;
#(
    parameter int  W         = DEF_W,
    parameter int  N_SAMPLES = DEF_N_SAMPLES,
    localparam int CW        = cnt_width(N_SAMPLES),
    localparam int SW        = sum_width(W, N_SAMPLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic [2*W-1:0]       y,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        sample_count,
    output logic [CW-1:0]        err_count,
    output logic [SW-1:0]        ed_sum,
    output logic [2*W-1:0]       ed_max
`ifdef ERR_BIAS_EN
    ,
    output logic signed [SW:0]   bias_sum,
    output logic [2*W-1:0]       ed_min_nz
`endif
);

    state_t         r_state;
    logic [CW-1:0]  r_sample_count;
    logic [CW-1:0]  r_err_count;
    logic [SW-1:0]  r_ed_sum;
    logic [2*W-1:0] r_ed_max;

    logic [2*W-1:0] w_exact;
    logic [2*W-1:0] w_ed;
    logic           w_err;
    logic           w_run;
    logic           w_accept;
    logic           w_clear;
    logic           w_last;

    err_dist #(.W(W)) u_err_dist (
        .i_a     (a),
        .i_b     (b),
        .i_y     (y),
        .o_exact (w_exact),
        .o_ed    (w_ed),
        .o_err   (w_err)
    );

    assign w_run    = (r_state == RUN);
    assign w_accept = in_valid && w_run;
    // A start outside RUN (IDLE or DONE) opens a new run and clears stats
    // on the same edge.
    assign w_clear  = start && !w_run;
    // The count still holds N_SAMPLES-1 on the edge that accepts the last one.
    assign w_last   = w_accept && (r_sample_count == CW'(N_SAMPLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: if (start)  r_state <= RUN;
                RUN:        if (w_last) r_state <= DONE;
                default:                r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_ed_sum       <= '0;
            r_ed_max       <= '0;
        end else if (w_clear) begin
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_ed_sum       <= '0;
            r_ed_max       <= '0;
        end else if (w_accept) begin
            r_sample_count <= r_sample_count + CW'(1);
            r_err_count    <= r_err_count + CW'(w_err);
            r_ed_sum       <= r_ed_sum + SW'(w_ed);
            if (w_ed > r_ed_max) begin
                r_ed_max <= w_ed;
            end
        end
    end

    assign in_ready     = w_run;
    assign busy         = w_run;
    assign done         = (r_state == DONE);
    assign sample_count = r_sample_count;
    assign err_count    = r_err_count;
    assign ed_sum       = r_ed_sum;
    assign ed_max       = r_ed_max;

`ifdef ERR_BIAS_EN
    logic signed [SW:0]    r_bias_sum;
    logic [2*W-1:0]        r_ed_min_nz;
    logic signed [2*W:0]   w_bias;

    // One extra bit so y - exact keeps its sign over the full unsigned range.
    assign w_bias = $signed({1'b0, y}) - $signed({1'b0, w_exact});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bias_sum  <= '0;
            r_ed_min_nz <= '1;
        end else if (w_clear) begin
            r_bias_sum  <= '0;
            r_ed_min_nz <= '1;
        end else if (w_accept) begin
            // Signed cast sign-extends the per-sample bias to the sum width.
            r_bias_sum <= r_bias_sum + (SW+1)'(w_bias);
            if (w_err && (w_ed < r_ed_min_nz)) begin
                r_ed_min_nz <= w_ed;
            end
        end
    end

    assign bias_sum  = r_bias_sum;
    assign ed_min_nz = r_ed_min_nz;
`endif

endmodule

// File: tb/tb_err_stats_4x4.sv
// tb_err_stats_4x4
// Randomized self-checking bench for err_stats_4x4. A run-level reference
// model (plain integer arithmetic over the accepted samples) predicts every
// output after every clock edge of the main instance (N_SAMPLES=256).
// A second instance with N_SAMPLES=4 exercises the handshake/stall pattern.
// Define ERR_BIAS_EN to also check bias_sum and ed_min_nz.
module tb_err_stats_4x4;

    localparam int W  = 4;
    localparam int N  = 256;
    localparam int NS = 4;
    localparam int CW = $clog2(N + 1);
    localparam int SW = 2 * W + CW;
    localparam int CWS = $clog2(NS + 1);
    localparam int SWS = 2 * W + CWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic           start = 1'b0, in_valid = 1'b0, in_ready, busy, done;
    logic [W-1:0]   a = '0, b = '0;
    logic [2*W-1:0] y = '0, ed_max;
    logic [CW-1:0]  sample_count, err_count;
    logic [SW-1:0]  ed_sum;
`ifdef ERR_BIAS_EN
    logic signed [SW:0] bias_sum;
    logic [2*W-1:0]     ed_min_nz;
`endif

    // small instance
    logic           s_start = 1'b0, s_in_valid = 1'b0, s_in_ready, s_busy, s_done;
    logic [W-1:0]   s_a = '0, s_b = '0;
    logic [2*W-1:0] s_y = '0, s_ed_max;
    logic [CWS-1:0] s_sample_count, s_err_count;
    logic [SWS-1:0] s_ed_sum;
`ifdef ERR_BIAS_EN
    logic signed [SWS:0] s_bias_sum;
    logic [2*W-1:0]      s_ed_min_nz;
`endif

    err_stats_4x4 #(.W(W), .N_SAMPLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .y(y), .busy(busy), .done(done),
        .sample_count(sample_count), .err_count(err_count),
        .ed_sum(ed_sum), .ed_max(ed_max)
`ifdef ERR_BIAS_EN
        , .bias_sum(bias_sum), .ed_min_nz(ed_min_nz)
`endif
    );

    err_stats_4x4 #(.W(W), .N_SAMPLES(NS)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .a(s_a), .b(s_b), .y(s_y), .busy(s_busy),
        .done(s_done), .sample_count(s_sample_count),
        .err_count(s_err_count), .ed_sum(s_ed_sum), .ed_max(s_ed_max)
`ifdef ERR_BIAS_EN
        , .bias_sum(s_bias_sum), .ed_min_nz(s_ed_min_nz)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (run level) ----------------
    // m_phase: 0 = idle, 1 = collecting samples, 2 = results held
    int     m_phase, m_cnt, m_err, m_max;
    longint m_sum;
`ifdef ERR_BIAS_EN
    longint m_bias;
    int     m_min;
`endif

    task automatic model_clear();
        m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0;
`ifdef ERR_BIAS_EN
        m_bias = 0; m_min = 255;
`endif
    endtask

    task automatic model_reset();
        m_phase = 0;
        model_clear();
    endtask

    task automatic model_edge(input logic st, input logic v, input int aa, input int bb, input int yy);
        int ex, ed;
        if (m_phase == 1) begin
            if (v) begin
                ex = aa * bb;
                ed = (ex > yy) ? ex - yy : yy - ex;
                m_cnt++;
                if (ed != 0) m_err++;
                m_sum += ed;
                if (ed > m_max) m_max = ed;
`ifdef ERR_BIAS_EN
                m_bias += yy - ex;
                if (ed != 0 && ed < m_min) m_min = ed;
`endif
                if (m_cnt == N) m_phase = 2;
            end
        end else if (st) begin
            m_phase = 1;
            model_clear();
        end
    endtask

    task automatic check_main();
        chk("in_ready", 64'(in_ready), 64'(m_phase == 1));
        chk("busy", 64'(busy), 64'(m_phase == 1));
        chk("done", 64'(done), 64'(m_phase == 2));
        chk("sample_count", 64'(sample_count), 64'(m_cnt));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("ed_sum", 64'(ed_sum), 64'(m_sum));
        chk("ed_max", 64'(ed_max), 64'(m_max));
`ifdef ERR_BIAS_EN
        chk("bias_sum", 64'($signed(bias_sum)), 64'(m_bias));
        chk("ed_min_nz", 64'(ed_min_nz), 64'(m_min));
`endif
    endtask

    // Drive one cycle on the main instance, advance model, then check.
    task automatic cycle(input logic st, input logic v, input int aa, input int bb, input int yy);
        start = st; in_valid = v; a = W'(aa); b = W'(bb); y = (2*W)'(yy);
        @(posedge clk);
        model_edge(st, v, aa, bb, yy);
        #1;
        check_main();
    endtask

    // Offer one sample, inserting random stall cycles first.
    task automatic feed(input int aa, input int bb, input int yy, input logic st);
        while ($urandom_range(0, 4) == 0) cycle(1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
        cycle(st, 1'b1, aa, bb, yy);
    endtask

    task automatic report(input string name);
        $display("run %-8s count=%0d err=%0d ed_sum=%0d ed_max=%0d done=%0d",
                 name, sample_count, err_count, ed_sum, ed_max, done);
    endtask

    initial begin
        int guard;
        int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int ecnt[7] = '{1, 1, 1, 2, 3, 3, 4};

        // ---- reset state ----
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_main();
        rst = 1'b0;
        repeat (3) cycle(1'b0, 1'b1, 5, 5, 25);   // in_ready stays low until start

        // ---- reset mid-run after 10 samples ----
        cycle(1'b1, 1'b0, 0, 0, 0);
        for (int k = 0; k < 10; k++) feed(k, 3, k * 3 + 1, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_main();                               // async: before any edge
        chk("rst_mid_count", 64'(sample_count), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) cycle(1'b0, 1'b1, 1, 1, 1);
        report("reset");

        // ---- exact stream, with an ignored start inside the run ----
        cycle(1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                feed(i, j, i * j, (i == 6 && j == 4));
        chk("exact_done", 64'(done), 64'd1);
        chk("exact_count", 64'(sample_count), 64'd256);
        chk("exact_err", 64'(err_count), 64'd0);
        chk("exact_sum", 64'(ed_sum), 64'd0);
        chk("exact_max", 64'(ed_max), 64'd0);
        repeat (3) cycle(1'b0, 1'b1, 2, 2, 0);      // not counted after done
        report("exact");

        // ---- single error, restart from DONE ----
        cycle(1'b1, 1'b0, 0, 0, 0);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_count", 64'(sample_count), 64'd0);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                feed(i, j, (i == 3 && j == 3) ? 8 : i * j, 1'b0);
        chk("single_err", 64'(err_count), 64'd1);
        chk("single_sum", 64'(ed_sum), 64'd1);
        chk("single_max", 64'(ed_max), 64'd1);
`ifdef ERR_BIAS_EN
        chk("single_bias", 64'($signed(bias_sum)), -64'sd1);
        chk("single_min", 64'(ed_min_nz), 64'd1);
`endif
        report("single");

        // ---- extreme error ----
        cycle(1'b1, 1'b0, 0, 0, 0);
        for (int k = 0; k < N; k++) feed(15, 15, 0, 1'b0);
        chk("extreme_err", 64'(err_count), 64'd256);
        chk("extreme_sum", 64'(ed_sum), 64'd57600);
        chk("extreme_max", 64'(ed_max), 64'd225);
        report("extreme");

        // ---- randomized runs ----
        for (int r = 0; r < 3; r++) begin
            cycle(1'b1, 1'b0, 0, 0, 0);
            guard = 0;
            while (m_phase == 1 && guard < 4000) begin
                int aa, bb, yy;
                aa = $urandom_range(0, 15);
                bb = $urandom_range(0, 15);
                yy = ($urandom_range(0, 1) == 0) ? aa * bb : $urandom_range(0, 255);
                cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, aa, bb, yy);
                guard++;
            end
            chk("rand_done", 64'(done), 64'd1);
            report("random");
        end

        // ---- small instance: stall pattern 1,0,0,1,1,0,1 ----
        s_start = 1'b1; s_in_valid = 1'b0;
        #1 chk("s_ready_start", 64'(s_in_ready), 64'd0);
        @(posedge clk); #1;
        s_start = 1'b0;
        chk("s_ready_run", 64'(s_in_ready), 64'd1);
        for (int k = 0; k < 7; k++) begin
            s_in_valid = pat[k][0];
            s_a = W'(k + 1); s_b = 4'd2; s_y = (2*W)'(2 * (k + 1) + 1);
            @(posedge clk); #1;
            chk("s_count", 64'(s_sample_count), 64'(ecnt[k]));
            chk("s_done", 64'(s_done), 64'(k == 6));
            chk("s_ready", 64'(s_in_ready), 64'(k != 6));
        end
        for (int k = 0; k < 3; k++) begin
            s_in_valid = 1'b1; s_a = 4'd9; s_b = 4'd9; s_y = 8'd0;
            @(posedge clk); #1;
            chk("s_count_after", 64'(s_sample_count), 64'd4);
            chk("s_done_held", 64'(s_done), 64'd1);
        end
        chk("s_err", 64'(s_err_count), 64'd4);
        chk("s_sum", 64'(s_ed_sum), 64'd4);
        s_in_valid = 1'b0;
        $display("run %-8s count=%0d err=%0d ed_sum=%0d done=%0d",
                 "stall", s_sample_count, s_err_count, s_ed_sum, s_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
